// File: rtl/game_sprite_mover_if.sv
// Control bundle between the game master FSM and one sprite mover.
// The FSM drives the write/enable strobes; the mover reports the on-screen flag.
interface game_sprite_mover_if #(
   parameter int X_WIDTH  = 10,
   parameter int Y_WIDTH  = 10,
   parameter int DX_WIDTH = 3,
   parameter int DY_WIDTH = 3
);
   logic                sprite_write_xy;
   logic                sprite_write_dxy;
   logic [X_WIDTH-1:0]  sprite_write_x;
   logic [Y_WIDTH-1:0]  sprite_write_y;
   logic [DX_WIDTH-1:0] sprite_write_dx;
   logic [DY_WIDTH-1:0] sprite_write_dy;
   logic                sprite_enable_update;
   logic                sprite_within_screen;

   modport master (
      output sprite_write_xy, sprite_write_dxy,
      output sprite_write_x, sprite_write_y,
      output sprite_write_dx, sprite_write_dy,
      output sprite_enable_update,
      input  sprite_within_screen
   );

   modport slave (
      input  sprite_write_xy, sprite_write_dxy,
      input  sprite_write_x, sprite_write_y,
      input  sprite_write_dx, sprite_write_dy,
      input  sprite_enable_update,
      output sprite_within_screen
   );
endinterface

// File: rtl/game_sprite_mover.sv
// Position/velocity engine for one sprite: strobed moves, on-screen flag,
// and a registered per-pixel hit flag for the collision stage.
module game_sprite_mover #(
   parameter int X_WIDTH       = 10,
   parameter int Y_WIDTH       = 10,
   parameter int DX_WIDTH      = 3,
   parameter int DY_WIDTH      = 3,
   parameter int SCREEN_WIDTH  = 640,
   parameter int SCREEN_HEIGHT = 480,
   parameter int SPRITE_WIDTH  = 8,
   parameter int SPRITE_HEIGHT = 8,
   parameter int STROBE_WIDTH  = 20
) (
   input  logic               clk,
   input  logic               reset_n,
   game_sprite_mover_if.slave bus,
   input  logic [X_WIDTH-1:0] pixel_x,
   input  logic [Y_WIDTH-1:0] pixel_y,
   output logic [X_WIDTH-1:0] sprite_x,
   output logic [Y_WIDTH-1:0] sprite_y,
   output logic               sprite_hit
);

   localparam int X_MAX = SCREEN_WIDTH - SPRITE_WIDTH;
   localparam int Y_MAX = SCREEN_HEIGHT - SPRITE_HEIGHT;

   logic [STROBE_WIDTH-1:0] strobe_cnt;
   logic [DX_WIDTH-1:0]     dx;
   logic [DY_WIDTH-1:0]     dy;
   logic                    move_strobe;
   logic                    do_move;
   logic [X_WIDTH-1:0]      dx_ext;
   logic [Y_WIDTH-1:0]      dy_ext;
   logic [X_WIDTH:0]        x_end;
   logic [Y_WIDTH:0]        y_end;
   logic                    hit_next;

   assign move_strobe = &strobe_cnt;
   assign do_move     = move_strobe & bus.sprite_enable_update;

   assign dx_ext = {{(X_WIDTH-DX_WIDTH){dx[DX_WIDTH-1]}}, dx};
   assign dy_ext = {{(Y_WIDTH-DY_WIDTH){dy[DY_WIDTH-1]}}, dy};

   // One extra bit keeps the box edge from wrapping near the right/bottom.
   assign x_end = {1'b0, sprite_x} + (X_WIDTH+1)'(SPRITE_WIDTH);
   assign y_end = {1'b0, sprite_y} + (Y_WIDTH+1)'(SPRITE_HEIGHT);

   assign hit_next = (pixel_x >= sprite_x)
                   & ({1'b0, pixel_x} < x_end)
                   & (pixel_y >= sprite_y)
                   & ({1'b0, pixel_y} < y_end);

   assign bus.sprite_within_screen =
      ({1'b0, sprite_x} <= (X_WIDTH+1)'(X_MAX)) &
      ({1'b0, sprite_y} <= (Y_WIDTH+1)'(Y_MAX));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         strobe_cnt <= '0;
      end else begin
         strobe_cnt <= strobe_cnt + 1'b1;
      end
   end

   // A position write wins over a move landing on the same edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sprite_x <= '0;
         sprite_y <= '0;
      end else if (bus.sprite_write_xy) begin
         sprite_x <= bus.sprite_write_x;
         sprite_y <= bus.sprite_write_y;
      end else if (do_move) begin
         sprite_x <= sprite_x + dx_ext;
         sprite_y <= sprite_y + dy_ext;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dx <= '0;
         dy <= '0;
      end else if (bus.sprite_write_dxy) begin
         dx <= bus.sprite_write_dx;
         dy <= bus.sprite_write_dy;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sprite_hit <= 1'b0;
      end else begin
         sprite_hit <= hit_next;
      end
   end

endmodule

// File: tb/tb_game_sprite_mover.sv
// Bench for game_sprite_mover: cycle model feeds a scoreboard queue,
// plus fixed-value checks at the interesting points.
module tb_game_sprite_mover;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [9:0] pixel_x = '0;
   logic [9:0] pixel_y = '0;
   logic [9:0] sprite_x;
   logic [9:0] sprite_y;
   logic       sprite_hit;

   game_sprite_mover_if #(.X_WIDTH(10), .Y_WIDTH(10),
                          .DX_WIDTH(3), .DY_WIDTH(3)) bus ();

   game_sprite_mover #(.STROBE_WIDTH(2)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .bus        (bus),
      .pixel_x    (pixel_x),
      .pixel_y    (pixel_y),
      .sprite_x   (sprite_x),
      .sprite_y   (sprite_y),
      .sprite_hit (sprite_hit)
   );

   always #5 clk = ~clk;

   typedef struct {
      int x;
      int y;
      int ws;
      int hit;
   } exp_t;

   exp_t sb[$];

   int n_chk = 0;
   int n_fail = 0;
   int m_cnt, m_x, m_y, m_dx, m_dy;
   bit last_strobe;

   task automatic check(input string tag, input int got, input int want);
      n_chk++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d", tag, got, want);
      end
   endtask

   task automatic model_reset();
      m_cnt = 0; m_x = 0; m_y = 0; m_dx = 0; m_dy = 0;
      sb.delete();
   endtask

   task automatic cycle();
      exp_t e;
      int nx, ny;
      bit strobe;
      strobe = (m_cnt == 3);
      e.hit = (int'(pixel_x) >= m_x && int'(pixel_x) < m_x + 8 &&
               int'(pixel_y) >= m_y && int'(pixel_y) < m_y + 8) ? 1 : 0;
      nx = m_x;
      ny = m_y;
      if (bus.sprite_write_xy) begin
         nx = int'(bus.sprite_write_x);
         ny = int'(bus.sprite_write_y);
      end else if (strobe && bus.sprite_enable_update) begin
         nx = (m_x + m_dx + 1024) % 1024;
         ny = (m_y + m_dy + 1024) % 1024;
      end
      if (bus.sprite_write_dxy) begin
         m_dx = $signed(bus.sprite_write_dx);
         m_dy = $signed(bus.sprite_write_dy);
      end
      m_cnt = (m_cnt + 1) % 4;
      m_x = nx;
      m_y = ny;
      e.x = nx;
      e.y = ny;
      e.ws = (nx <= 632 && ny <= 472) ? 1 : 0;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check("sb_x", int'(sprite_x), e.x);
      check("sb_y", int'(sprite_y), e.y);
      check("sb_ws", int'(bus.sprite_within_screen), e.ws);
      check("sb_hit", int'(sprite_hit), e.hit);
      last_strobe = strobe;
   endtask

   task automatic idle_writes();
      bus.sprite_write_xy = 1'b0;
      bus.sprite_write_dxy = 1'b0;
   endtask

   task automatic wait_strobe(input string tag);
      bit seen;
      seen = 0;
      for (int i = 0; i < 8 && !seen; i++) begin
         cycle();
         seen = last_strobe && bus.sprite_enable_update;
      end
      check(tag, int'(seen), 1);
   endtask

   task automatic write_xy(input int x, input int y);
      bus.sprite_write_xy = 1'b1;
      bus.sprite_write_x = 10'(x);
      bus.sprite_write_y = 10'(y);
   endtask

   task automatic write_dxy(input int dx, input int dy);
      bus.sprite_write_dxy = 1'b1;
      bus.sprite_write_dx = 3'(dx);
      bus.sprite_write_dy = 3'(dy);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      idle_writes();
      bus.sprite_write_x = '0;
      bus.sprite_write_y = '0;
      bus.sprite_write_dx = '0;
      bus.sprite_write_dy = '0;
      bus.sprite_enable_update = 1'b0;
      model_reset();

      repeat (2) @(posedge clk);
      #1;
      check("rst_x", int'(sprite_x), 0);
      check("rst_y", int'(sprite_y), 0);
      check("rst_ws", int'(bus.sprite_within_screen), 1);
      check("rst_hit", int'(sprite_hit), 0);
      @(negedge clk);
      reset_n = 1'b1;

      repeat (20) cycle();
      check("idle_x", int'(sprite_x), 0);
      check("idle_y", int'(sprite_y), 0);

      write_xy(100, 50);
      write_dxy(1, -1);
      bus.sprite_enable_update = 1'b1;
      cycle();
      idle_writes();
      wait_strobe("strobe1");
      check("mv1_x", int'(sprite_x), 101);
      check("mv1_y", int'(sprite_y), 49);
      repeat (4) cycle();
      check("mv2_x", int'(sprite_x), 102);
      check("mv2_y", int'(sprite_y), 48);

      bus.sprite_enable_update = 1'b0;
      write_xy(632, 100);
      write_dxy(1, 0);
      cycle();
      idle_writes();
      check("edge_ws_in", int'(bus.sprite_within_screen), 1);
      bus.sprite_enable_update = 1'b1;
      wait_strobe("strobe2");
      check("edge_x", int'(sprite_x), 633);
      check("edge_ws_out", int'(bus.sprite_within_screen), 0);

      bus.sprite_enable_update = 1'b0;
      write_xy(200, 0);
      write_dxy(0, -1);
      cycle();
      idle_writes();
      bus.sprite_enable_update = 1'b1;
      wait_strobe("strobe3");
      check("wrap_y", int'(sprite_y), 1023);
      check("wrap_ws", int'(bus.sprite_within_screen), 0);

      write_dxy(3, 3);
      cycle();
      idle_writes();
      for (int i = 0; i < 4 && m_cnt != 3; i++) cycle();
      write_xy(300, 300);
      cycle();
      idle_writes();
      check("wr_pri_strobe", int'(last_strobe), 1);
      check("wr_pri_x", int'(sprite_x), 300);
      check("wr_pri_y", int'(sprite_y), 300);

      bus.sprite_enable_update = 1'b0;
      repeat (8) cycle();
      check("lost_x", int'(sprite_x), 300);

      write_xy(10, 20);
      cycle();
      idle_writes();
      pixel_x = 10'd10; pixel_y = 10'd20;
      cycle();
      check("hit_10_20", int'(sprite_hit), 1);
      pixel_x = 10'd18; pixel_y = 10'd20;
      cycle();
      check("hit_18_20", int'(sprite_hit), 0);
      pixel_x = 10'd17; pixel_y = 10'd27;
      cycle();
      check("hit_17_27", int'(sprite_hit), 1);
      pixel_x = 10'd9; pixel_y = 10'd20;
      cycle();
      check("hit_9_20", int'(sprite_hit), 0);
      pixel_x = 10'd12; pixel_y = 10'd28;
      cycle();
      check("hit_12_28", int'(sprite_hit), 0);
      pixel_x = 10'd12; pixel_y = 10'd22;

      bus.sprite_enable_update = 1'b1;
      cycle();
      #2;
      reset_n = 1'b0;
      #1;
      check("mid_rst_x", int'(sprite_x), 0);
      check("mid_rst_y", int'(sprite_y), 0);
      check("mid_rst_hit", int'(sprite_hit), 0);
      check("mid_rst_ws", int'(bus.sprite_within_screen), 1);
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();
      pixel_x = '0; pixel_y = '0;
      write_dxy(1, 1);
      cycle();
      idle_writes();
      repeat (2) cycle();
      check("restart_hold", int'(sprite_x), 0);
      cycle();
      check("restart_move", int'(sprite_x), 1);
      repeat (4) cycle();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
